audio_i2s_tx: RTL
=================

// Module: audio_i2s_tx
// PURPOSE
// - I2S serializer for the PSG stereo output. Master: generates BCK/LRCK from clk.
// - Pulls one stereo sample per frame: strobes next_sample, latches left/right_audio.
// - Shifts samples MSB-first to an external DAC. 64 BCK per frame, 32 per slot.
// - Sample rate = clk / (128*CLK_DIV); e.g. 25 MHz, CLK_DIV=4 -> 48.828 kHz.
// PARAMETERS
// - CLK_DIV  4  clk cycles per BCK half-period; legal range 1..255
// PORTS
// - clk          in   1   system clock
// - rst          in   1   reset, asynchronous, active-high
// - en           in   1   run enable; low = idle, outputs low
// - left_audio   in   16  signed left sample, sampled at latch event only
// - right_audio  in   16  signed right sample, sampled at latch event only
// - next_sample  out  1   1-clk pulse once per frame; request next sample from PSG
// - i2s_bck      out  1   bit clock; data changes on falling edge
// - i2s_lrck     out  1   word select; 0 = left slot, 1 = right slot
// - i2s_data     out  1   serial data, MSB first
// BEHAVIOUR
// - Reset: state IDLE, div_r=0, pos_r=0, hold regs=0; all outputs 0.
// - FSM IDLE: outputs 0, counters/holds cleared; en=1 -> RUN next clk.
// - FSM RUN: en=0 -> IDLE on the next clk, mid-frame or not; no next_sample pulse.
// - div_r counts 0..CLK_DIV-1; at CLK_DIV-1 wraps to 0 and toggles i2s_bck.
// - Falling BCK event (bck 1->0 toggle): pos_r (6 bit) increments, 63 wraps to 0.
// - Re-entry to RUN: bck=0, pos_r=0, so first falling edge moves pos_r to 1.
// - i2s_lrck = pos_r[5]; slot position p = pos_r[4:0]; slot sample s = L or R hold.
// - i2s_data, I2S mode: p in 1..16 -> s[16-p]; all other p -> 0.
// - i2s_data, LJ mode: see CONFIGURATION.
// - All outputs registered; they change in the same clk cycle as the bck fall.
// - Latch event: falling edge that moves pos_r to 63.
// - At latch event: hold_l<=left_audio, hold_r<=right_audio; next_sample=1 that clk.
// - Latch and pos 63 are safe: data bit is 0 at p=31 in both modes.
// - Latched pair plays from pos 0 of the next frame, i.e. 1 BCK after latch.
// - The sample the PSG makes for this request is latched at the next event, 1 frame later.
// - next_sample period = 128*CLK_DIV clk cycles; pulse is exactly 1 clk wide.
// - Input changes between latch events have no effect on the output.
// - CLK_DIV=1: bck toggles every clk; all rules above still hold.
// - No widening: 16-bit samples in 32-bit slots, remaining slot bits are 0.
// - rst mid-frame: immediate async clear to reset values; restart via IDLE->RUN.
// CONFIGURATION
// - AUDIO_I2S_LEFT_JUSTIFIED_EN undefined: standard I2S; MSB 1 BCK after LRCK edge.
// - AUDIO_I2S_LEFT_JUSTIFIED_EN defined: left-justified; p in 0..15 -> s[15-p].
// - LJ mode: MSB coincides with the LRCK edge; p 16..31 -> 0.
// - LRCK polarity, latch timing and next_sample timing are identical in both builds.
// TESTING
// - Reset: rst=1 with en=1 -> bck/lrck/data/next_sample all 0; after release, IDLE then RUN.
// - Cadence: CLK_DIV=2, en=1 -> bck period 4 clk, 1 next_sample pulse per 256 clk.
// - Cadence, cont.: check pulse width 1 clk and lrck high for 128 clk per frame.
// - I2S data: L=16'h8001, R=16'h7FFE.
// - I2S data, left slot: pos 1..16 = 1,0x14,1 then 0s.
// - I2S data, right slot: pos 33..48 = 0,1x14,0 then 0s.
// - Latch isolation: change inputs right after a next_sample pulse.
// - Latch isolation, result: current frame unchanged; new values appear only after the next pulse.
// - Enable drop: en=0 at pos 20 -> all outputs 0 next clk, no pulse.
// - Enable drop, restart: re-enable -> frame restarts at pos 0 with zero holds.
// - LJ build with L=16'hC000: left slot pos 0,1 = 1,1 and pos 2..31 = 0.
// - LJ build, cont.: lrck falls in the same clk as the MSB.

Source files
------------

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S master serializer for the PSG stereo output.
//
// Generates BCK and LRCK from clk and shifts one 16-bit stereo sample pair per
// frame to an external DAC, MSB first. A frame is 64 BCK periods (32 per slot),
// so the sample rate is clk / (128 * CLK_DIV). Once per frame next_sample pulses
// for one clk while left_audio/right_audio are latched into the hold registers.
// That pair starts playing one BCK later, at position 0 of the following frame.
//
// Build option: define AUDIO_I2S_LEFT_JUSTIFIED_EN for left-justified framing
// (MSB aligned with the LRCK edge). The default build is standard I2S
// (MSB one BCK after the LRCK edge).
//
// Parameters:
//   CLK_DIV      clk cycles per BCK half-period, 1..255
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   en           in   run enable; low forces idle with all outputs low
//   left_audio   in   [15:0] signed left sample, sampled at the latch event only
//   right_audio  in   [15:0] signed right sample, sampled at the latch event only
//   next_sample  out  1-clk request pulse, once per frame
//   i2s_bck      out  bit clock; data changes on its falling edge
//   i2s_lrck     out  word select; 0 = left slot, 1 = right slot
//   i2s_data     out  serial data, MSB first
`timescale 1ns/1ps

module audio_i2s_tx #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] left_audio,
    input  logic [15:0] right_audio,
    output logic        next_sample,
    output logic        i2s_bck,
    output logic        i2s_lrck,
    output logic        i2s_data
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    typedef enum logic {StIdle, StRun} state_t;

    state_t          state;
    logic [DivW-1:0] div_r;
    logic [5:0]      pos_r;
    logic [15:0]     hold_l;
    logic [15:0]     hold_r;

    // Position and data bit that take effect at the next falling BCK edge.
    logic [5:0]  pos_nxt;
    logic [4:0]  slot_pos;
    logic [15:0] slot_smp;
    logic [4:0]  bit_idx;
    logic        bit_nxt;

    assign pos_nxt  = pos_r + 6'd1;
    assign slot_pos = pos_nxt[4:0];
    assign slot_smp = pos_nxt[5] ? hold_r : hold_l;

`ifdef AUDIO_I2S_LEFT_JUSTIFIED_EN
    // Left-justified: bit 15 at slot position 0.
    assign bit_idx = 5'd15 - slot_pos;
    always_comb begin
        bit_nxt = 1'b0;
        if (slot_pos <= 5'd15) begin
            bit_nxt = slot_smp[bit_idx[3:0]];
        end
    end
`else
    // I2S: bit 15 at slot position 1, one BCK after the LRCK edge.
    assign bit_idx = 5'd16 - slot_pos;
    always_comb begin
        bit_nxt = 1'b0;
        if ((slot_pos >= 5'd1) && (slot_pos <= 5'd16)) begin
            bit_nxt = slot_smp[bit_idx[3:0]];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            div_r       <= '0;
            pos_r       <= '0;
            hold_l      <= '0;
            hold_r      <= '0;
            next_sample <= 1'b0;
            i2s_bck     <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_data    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    div_r       <= '0;
                    pos_r       <= '0;
                    hold_l      <= '0;
                    hold_r      <= '0;
                    next_sample <= 1'b0;
                    i2s_bck     <= 1'b0;
                    i2s_lrck    <= 1'b0;
                    i2s_data    <= 1'b0;
                    if (en) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    next_sample <= 1'b0;
                    if (!en) begin
                        // Abandon the frame immediately; no request is issued.
                        state    <= StIdle;
                        div_r    <= '0;
                        pos_r    <= '0;
                        hold_l   <= '0;
                        hold_r   <= '0;
                        i2s_bck  <= 1'b0;
                        i2s_lrck <= 1'b0;
                        i2s_data <= 1'b0;
                    end else if (div_r == DivLast) begin
                        div_r   <= '0;
                        i2s_bck <= ~i2s_bck;
                        if (i2s_bck) begin
                            // Falling BCK: advance and present the new bit.
                            pos_r    <= pos_nxt;
                            i2s_lrck <= pos_nxt[5];
                            i2s_data <= bit_nxt;
                            // Position 63 carries a zero bit in both framings,
                            // so the holds can be swapped here safely.
                            if (pos_nxt == 6'd63) begin
                                hold_l      <= left_audio;
                                hold_r      <= right_audio;
                                next_sample <= 1'b1;
                            end
                        end
                    end else begin
                        div_r <= div_r + DivW'(1);
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
